// File: rtl/uart_pkg.sv
// Shared UART types and elaboration helpers: parity modes, receiver states,
// and the parity-name / baud-divisor conversion functions.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_MARK,
    PAR_SPACE
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK
  } rx_state_t;

  localparam int PARITY_CHARS = 5;

  // The parity name arrives as packed ASCII, right-aligned and zero-padded.
  function automatic parity_t str2parity(input logic [8*PARITY_CHARS-1:0] name);
    parity_t mode;
    mode = PAR_NONE;
    if (name == 40'("even"))  mode = PAR_EVEN;
    if (name == 40'("odd"))   mode = PAR_ODD;
    if (name == 40'("mark"))  mode = PAR_MARK;
    if (name == 40'("space")) mode = PAR_SPACE;
    return mode;
  endfunction

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is presented
// combinationally and reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = LW'(wr_ptr_reg - rd_ptr_reg);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop; a pop on empty is ignored.
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, deframes start/data/parity/stop bits,
// pushes clean words into a FWFT FIFO and keeps sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_   = 50000000,
  parameter int BAUD_  = 115200,
  parameter int DATA_  = 8,
  parameter int STOP_  = 1,
  parameter     PARITY = "none",
  parameter int BUFF_  = 64
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       rx,
  input  logic                       re,
  input  logic                       clr,
  output logic [DATA_-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(BUFF_+1)-1:0] level,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun
);

  localparam int      DIV        = baud_div(CLK_, BAUD_);
  localparam int      HALF       = DIV / 2;
  localparam int      CW         = $clog2(DIV);
  localparam int      IW         = $clog2(DATA_);
  localparam parity_t PMODE      = str2parity(40'(PARITY));
  localparam bit      HAS_PAR    = (PMODE != PAR_NONE);
  localparam int      FRAME_BITS = 1 + DATA_ + (HAS_PAR ? 1 : 0) + STOP_;
  localparam int      HOLDOFF    = FRAME_BITS * DIV;
  localparam int      HW         = $clog2(HOLDOFF + 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx: clock/baud divisor must be at least 4");
  end
  if ((BUFF_ < 2) || ((BUFF_ & (BUFF_ - 1)) != 0)) begin : g_buff_chk
    $error("uart_rx: BUFF_ must be a power of two, at least 2");
  end
  if ((DATA_ < 5) || (DATA_ > 9)) begin : g_data_chk
    $error("uart_rx: DATA_ must be in 5..9");
  end
  if ((STOP_ < 1) || (STOP_ > 2)) begin : g_stop_chk
    $error("uart_rx: STOP_ must be 1 or 2");
  end

  logic             sync1_reg, rxs_reg, rxs_d_reg;
  logic             fall, tick, stop_bad, par_exp;
  rx_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [DATA_-1:0] shreg_reg, shreg_next;
  logic             perr_reg, perr_next;
  logic             ferr_reg, ferr_next;
  logic             armed_reg;
  logic [HW-1:0]    idle_cnt_reg;
  logic             push, set_perr, set_ferr, drop;
  logic             frame_err_reg, parity_err_reg, overrun_reg;

  always_ff @(posedge clk) begin
    if (rst_) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
      rxs_d_reg <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rxs_reg   <= sync1_reg;
      rxs_d_reg <= rxs_reg;
    end
  end

  assign fall     = rxs_d_reg & ~rxs_reg;
  assign tick     = (cnt_reg == CW'(HALF));
  assign stop_bad = ferr_reg | ~rxs_reg;

  // After reset the line may be mid-frame; only arm start detection once
  // it has been high for a whole frame, so a frame tail is never decoded.
  always_ff @(posedge clk) begin
    if (rst_) begin
      armed_reg    <= 1'b0;
      idle_cnt_reg <= '0;
    end else if (!armed_reg) begin
      if (!rxs_reg) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg == HW'(HOLDOFF - 1)) begin
        armed_reg <= 1'b1;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    case (PMODE)
      PAR_EVEN: par_exp = ^shreg_reg;
      PAR_ODD:  par_exp = ~^shreg_reg;
      PAR_MARK: par_exp = 1'b1;
      default:  par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shreg_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg == CW'(DIV - 1)) ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    push       = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Holding the counter at zero makes START always begin from a reload.
        cnt_next  = '0;
        idx_next  = '0;
        perr_next = 1'b0;
        ferr_next = 1'b0;
        if (armed_reg && fall) state_next = START;
      end
      START: begin
        if (tick) begin
          if (rxs_reg) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            idx_next   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = {rxs_reg, shreg_reg[DATA_-1:1]};
          if (idx_reg == IW'(DATA_ - 1)) begin
            idx_next   = '0;
            state_next = HAS_PAR ? PAR : STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          if (rxs_reg != par_exp) perr_next = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (idx_reg == IW'(STOP_ - 1)) begin
            set_ferr   = stop_bad;
            set_perr   = perr_reg;
            push       = ~stop_bad & ~perr_reg;
            state_next = stop_bad ? BRK : IDLE;
          end else begin
            ferr_next = stop_bad;
            idx_next  = idx_reg + 1'b1;
          end
        end
      end
      BRK: begin
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_),
    .DEPTH (BUFF_)
  ) u_fifo (
    .clk     (clk),
    .srst    (rst_),
    .wr_en   (push),
    .wr_data (shreg_reg),
    .rd_en   (re),
    .rd_data (dout),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign drop = push & full & ~re;

  // A new error in the same cycle as clr wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst_) begin
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_err_reg  <= set_ferr | (frame_err_reg & ~clr);
      parity_err_reg <= set_perr | (parity_err_reg & ~clr);
      overrun_reg    <= drop | (overrun_reg & ~clr);
    end
  end

  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three receivers (no parity, even, odd with two
// stop bits) driven by directed and random frames against a frame-level model.
module tb_uart_rx;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  typedef struct {
    int         inst;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_;
  logic [2:0] rx_l, re, re_mon, re_man, clr, auto_rd;
  logic [7:0] dout [3];
  logic [2:0] level [3];
  logic [2:0] empty, full, frame_err, parity_err, overrun;

  int   par_mode [3] = '{0, 1, 2};
  int   stop_n   [3] = '{1, 1, 2};
  bit   exp_ferr [3];
  bit   exp_perr [3];
  bit   exp_ovr  [3];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   lat      = 0;

  assign re = re_mon | re_man;

  uart_rx #(.CLK_(1000000), .BAUD_(100000), .DATA_(8), .STOP_(1), .PARITY("none"), .BUFF_(DEPTH)) u_none (
    .clk(clk), .rst_(rst_), .rx(rx_l[0]), .re(re[0]), .clr(clr[0]), .dout(dout[0]),
    .empty(empty[0]), .full(full[0]), .level(level[0]), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .overrun(overrun[0]));

  uart_rx #(.CLK_(1000000), .BAUD_(100000), .DATA_(8), .STOP_(1), .PARITY("even"), .BUFF_(DEPTH)) u_even (
    .clk(clk), .rst_(rst_), .rx(rx_l[1]), .re(re[1]), .clr(clr[1]), .dout(dout[1]),
    .empty(empty[1]), .full(full[1]), .level(level[1]), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .overrun(overrun[1]));

  uart_rx #(.CLK_(1000000), .BAUD_(100000), .DATA_(8), .STOP_(2), .PARITY("odd"), .BUFF_(DEPTH)) u_odd (
    .clk(clk), .rst_(rst_), .rx(rx_l[2]), .re(re[2]), .clr(clr[2]), .dout(dout[2]),
    .empty(empty[2]), .full(full[2]), .level(level[2]), .frame_err(frame_err[2]),
    .parity_err(parity_err[2]), .overrun(overrun[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- frame-level reference model ----
  function automatic bit model_parity(input int i, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return (par_mode[i] == 1) ? bit'(ones % 2) : bit'(1 - (ones % 2));
  endfunction

  function automatic int occupancy(input int i);
    int n;
    n = 0;
    foreach (sb[k]) if (sb[k].inst == i) n++;
    return n;
  endfunction

  function automatic int find_first(input int i);
    foreach (sb[k]) if (sb[k].inst == i) return k;
    return -1;
  endfunction

  // ---- line drivers ----
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int i, input logic b);
    rx_l[i] = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int i, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
    @(posedge clk);
    #1;
    drive_bit(i, 1'b0);
    for (int b = 0; b < 8; b++) drive_bit(i, d[b]);
    if (par_mode[i] != 0) drive_bit(i, pbit);
    for (int s = 0; s < stop_n[i]; s++) drive_bit(i, stops[s]);
    rx_l[i] = 1'b1;
  endtask

  // Expectation is recorded before the frame goes out, then the frame is driven.
  task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                            input logic [1:0] stops, input bit pop_at_push);
    bit perr, ferr;
    int occ;
    exp_t e;
    perr = (par_mode[i] != 0) && bad_par;
    ferr = (stops[0] == 1'b0) || ((stop_n[i] == 2) && (stops[1] == 1'b0));
    if (!perr && !ferr) begin
      occ = occupancy(i) - (pop_at_push ? 1 : 0);
      if (occ < DEPTH) begin
        e.inst = i;
        e.data = d;
        sb.push_back(e);
      end else begin
        exp_ovr[i] = 1'b1;
      end
    end
    exp_ferr[i] |= ferr;
    exp_perr[i] |= perr;
    drive_frame(i, d, model_parity(i, d) ^ bad_par, stops);
  endtask

  task automatic manual_read(input int i);
    int k;
    k = find_first(i);
    n_checks++;
    if (k < 0) begin
      n_err++;
      $display("FAIL manual read rx%0d: dout=0x%0h but model holds no word", i, dout[i]);
    end else begin
      if (dout[i] !== sb[k].data) begin
        n_err++;
        $display("FAIL manual read rx%0d: got 0x%0h, expected 0x%0h", i, dout[i], sb[k].data);
      end
      sb.delete(k);
    end
    re_man[i] = 1'b1;
    @(posedge clk);
    #1;
    re_man[i] = 1'b0;
  endtask

  task automatic check_flags(input int i);
    check($sformatf("frame_err[%0d]", i), frame_err[i], exp_ferr[i]);
    check($sformatf("parity_err[%0d]", i), parity_err[i], exp_perr[i]);
    check($sformatf("overrun[%0d]", i), overrun[i], exp_ovr[i]);
  endtask

  task automatic clear_flags(input int i);
    @(posedge clk);
    #1;
    clr[i] = 1'b1;
    @(posedge clk);
    #1;
    clr[i] = 1'b0;
    exp_ferr[i] = 1'b0;
    exp_perr[i] = 1'b0;
    exp_ovr[i]  = 1'b0;
  endtask

  task automatic check_fifo(input string name, input int i);
    check({name, " level"}, level[i], occupancy(i));
    check({name, " empty"}, empty[i], occupancy(i) == 0);
    check({name, " full"}, full[i], occupancy(i) == DEPTH);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0) && (k < 100)) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset outputs rx%0d", i),
            {empty[i], full[i], level[i], dout[i], frame_err[i], parity_err[i], overrun[i]},
            32'h8000);
    end
  endtask

  // ---- monitor: pops the scoreboard whenever a receiver presents a word ----
  always @(negedge clk) begin
    int k;
    re_mon = '0;
    for (int i = 0; i < 3; i++) begin
      if (auto_rd[i] && !empty[i] && !rst_) begin
        k = find_first(i);
        n_checks++;
        if (k < 0) begin
          n_err++;
          $display("FAIL rx%0d word: got 0x%0h, expected no word", i, dout[i]);
        end else begin
          if (dout[i] !== sb[k].data) begin
            n_err++;
            $display("FAIL rx%0d word: got 0x%0h, expected 0x%0h", i, dout[i], sb[k].data);
          end else begin
            $display("rx%0d word 0x%0h ok", i, dout[i]);
          end
          sb.delete(k);
        end
        re_mon[i] = 1'b1;
      end
    end
  end

  initial begin
    rx_l    = '1;
    re_man  = '0;
    clr     = '0;
    auto_rd = '1;
    rst_    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    check_reset_state();
    idle(200);

    // 1: no parity, first-word latency and FWFT read
    auto_rd[0] = 1'b0;
    fork
      send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0);
      begin
        @(posedge clk);
        lat = 0;
        while (empty[0] && (lat < 300)) begin
          @(posedge clk);
          #2;
          lat++;
        end
      end
    join
    n_checks++;
    if ((lat < 90) || (lat > 105)) begin
      n_err++;
      $display("FAIL first word latency: got %0d clk, expected 90..105", lat);
    end
    check_fifo("one word held", 0);
    manual_read(0);
    check_fifo("after read", 0);
    auto_rd[0] = 1'b1;

    // 2: even parity, good then bad parity bit
    auto_rd[1] = 1'b0;
    send_frame(1, 8'h07, 1'b0, 2'b11, 1'b0);
    idle(20);
    check_fifo("even good", 1);
    check_flags(1);
    send_frame(1, 8'h07, 1'b1, 2'b11, 1'b0);
    idle(20);
    check_fifo("even bad parity", 1);
    check_flags(1);
    clear_flags(1);
    check_flags(1);
    auto_rd[1] = 1'b1;
    wait_drain();

    // 3: glitch, bad stop bit, long break, recovery
    @(posedge clk);
    #1;
    rx_l[0] = 1'b0;
    idle(3);
    rx_l[0] = 1'b1;
    idle(50);
    check_fifo("after glitch", 0);
    send_frame(0, 8'h3C, 1'b0, 2'b10, 1'b0);
    idle(20);
    check_flags(0);
    clear_flags(0);
    @(posedge clk);
    #1;
    rx_l[0] = 1'b0;
    idle(12 * DIV);
    check("break frame_err", frame_err[0], 1);
    clear_flags(0);
    idle(18 * DIV);
    rx_l[0] = 1'b1;
    idle(20 * DIV);
    check("break single frame_err", frame_err[0], 0);
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0);
    wait_drain();
    check_flags(0);

    // 4: overflow without and with a pop in the push cycle
    for (int pass = 0; pass < 2; pass++) begin
      auto_rd[0] = 1'b0;
      for (int w = 1; w <= 4; w++) send_frame(0, 8'(w), 1'b0, 2'b11, 1'b0);
      idle(2 * DIV);
      check_fifo("four words", 0);
      if (pass == 0) begin
        send_frame(0, 8'h05, 1'b0, 2'b11, 1'b0);
      end else begin
        fork
          send_frame(0, 8'h05, 1'b0, 2'b11, 1'b1);
          begin
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1;
            manual_read(0);
          end
        join
      end
      idle(2 * DIV);
      check_fifo("after fifth word", 0);
      check_flags(0);
      auto_rd[0] = 1'b1;
      wait_drain();
      clear_flags(0);
    end

    // 5: reset in the middle of data bit 4
    fork
      drive_frame(0, 8'h5A, 1'b0, 2'b11);
      begin
        @(posedge clk);
        repeat (5 * DIV + DIV / 2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        rst_ = 1'b0;
        check_reset_state();
      end
    join
    idle(25 * DIV);
    check_fifo("after mid-frame reset", 0);
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b0);
    wait_drain();
    check_flags(0);

    // 6: odd parity, two stop bits
    send_frame(2, 8'h00, 1'b0, 2'b11, 1'b0);
    wait_drain();
    check_flags(2);
    send_frame(2, 8'h00, 1'b0, 2'b01, 1'b0);
    idle(20);
    check_flags(2);
    clear_flags(2);

    // random frames across all receivers
    for (int n = 0; n < 24; n++) begin
      int         i;
      logic [7:0] d;
      bit         bad;
      logic [1:0] stops;
      i     = $urandom_range(0, 2);
      d     = 8'($urandom);
      bad   = ($urandom_range(0, 5) == 0);
      stops = 2'b11;
      if ($urandom_range(0, 7) == 0) stops[$urandom_range(0, stop_n[i] - 1)] = 1'b0;
      send_frame(i, d, bad, stops, 1'b0);
      idle(2 * DIV);
      wait_drain();
      check_flags(i);
      clear_flags(i);
    end

    idle(50);
    check("final scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
